ifetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction cache. Holds the PC and issues one-cycle read pulses to the icache, keeping at most one request outstanding. Captures returned words into a 2-entry buffer toward decode with ready/valid backpressure. Handles branch/jump redirects by flushing the buffer and discarding any stale in-flight response.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_if.sv | 25 ++
 rtl/ifetch_fetch_buf.sv | 53 +++++
 rtl/ifetch.sv | 99 +++++++++
 tb/tb_ifetch.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and types for the instruction fetch stage
package ifetch_pkg;

    localparam int          MEM_SCALE_DEF = 27;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam int          BUF_DEPTH     = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - icache request/response and decode handoff signals of the fetch stage
interface ifetch_if
    import ifetch_pkg::*;
#(
    parameter int MEM_SCALE = MEM_SCALE_DEF
);
    logic                 ic_oe;
    logic [MEM_SCALE-1:0] ic_addr;
    logic [31:0]          ic_rdata;
    logic                 ic_valid;
    logic                 inst_valid;
    logic [31:0]          inst;
    logic [31:0]          inst_pc;
    logic                 inst_ready;

    modport master (
        output ic_oe, ic_addr, inst_valid, inst, inst_pc,
        input  ic_rdata, ic_valid, inst_ready
    );

    modport slave (
        input  ic_oe, ic_addr, inst_valid, inst, inst_pc,
        output ic_rdata, ic_valid, inst_ready
    );
endinterface

// File: rtl/ifetch_fetch_buf.sv
// rtl/ifetch_fetch_buf.sv - DEPTH-entry FIFO of fetched {pc, inst}; flush beats push and pop
module fetch_buf
    import ifetch_pkg::*;
#(
    parameter int  DEPTH = BUF_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wr_data,
    output fetch_entry_t  rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push_ok;
    logic            pop_ok;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush && !rst) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - PC/request control in front of the icache, one request in flight,
// stale responses dropped after a redirect.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          MEM_SCALE = MEM_SCALE_DEF,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          DEPTH     = BUF_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    ifetch_if.master     bus,
    output logic [31:0]  if_cnt_issue,
    output logic [31:0]  if_cnt_discard
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         outstanding;
    logic         stale;
    logic         push;
    logic         pop;
    logic         drop;
    logic         room;
    logic         issue;
    logic [OW-1:0] next_occ;
    logic [CW-1:0] occ;
    logic         buf_empty;
    logic         buf_full;
    fetch_entry_t head;
    fetch_entry_t tail;

    assign pop      = ~buf_empty & bus.inst_ready;
    assign push     = bus.ic_valid & outstanding & ~stale & ~redirect;
    assign drop     = bus.ic_valid & outstanding & (stale | redirect);
    assign next_occ = {1'b0, occ} + OW'(push) - OW'(pop);
    assign room     = next_occ < OW'(DEPTH);
    // The next request may go out in the very cycle the previous response lands.
    assign issue    = ~rst & ~redirect & (~outstanding | bus.ic_valid) & room;

    assign bus.ic_oe      = issue;
    assign bus.ic_addr    = pc[MEM_SCALE+1:2];
    assign bus.inst_valid = ~buf_empty;
    assign bus.inst       = buf_empty ? NOP_INST : head.inst;
    assign bus.inst_pc    = head.pc;
    assign tail           = '{pc: req_pc, inst: bus.ic_rdata};

    fetch_buf #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (tail),
        .rd_data (head),
        .full    (buf_full),
        .empty   (buf_empty),
        .count   (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            req_pc         <= RESET_PC;
            outstanding    <= 1'b0;
            stale          <= 1'b0;
            if_cnt_issue   <= '0;
            if_cnt_discard <= '0;
        end else begin
            if (redirect)   pc <= redirect_pc & ~32'd3;
            else if (issue) pc <= pc + 32'd4;

            if (issue) begin
                req_pc       <= pc;
                outstanding  <= 1'b1;
                if_cnt_issue <= if_cnt_issue + 32'd1;
            end else if (bus.ic_valid) begin
                outstanding  <= 1'b0;
            end

            // A redirect with the old fetch still in flight marks its response for disposal.
            if (drop) begin
                stale          <= 1'b0;
                if_cnt_discard <= if_cnt_discard + 32'd1;
            end else if (redirect && outstanding && !bus.ic_valid) begin
                stale          <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(buf_full && push && !pop));
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed-vector bench for ifetch with a latency-programmable icache model
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_cnt_issue;
    logic [31:0] if_cnt_discard;

    ifetch_if bus ();

    ifetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .bus            (bus),
        .if_cnt_issue   (if_cnt_issue),
        .if_cnt_discard (if_cnt_discard)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    bit          m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    int          lat;

    logic [31:0] s_oe, s_addr, s_iv, s_inst, s_ipc, s_iss, s_dis;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive the icache response, sample mid-cycle, then advance the model at the edge.
    task automatic cyc();
        bus.ic_valid = !rst && m_pend && (m_cnt == 0);
        bus.ic_rdata = bus.ic_valid ? word_of(m_addr) : 32'h0;
        #2;
        s_oe   = 32'(bus.ic_oe);
        s_addr = 32'(bus.ic_addr);
        s_iv   = 32'(bus.inst_valid);
        s_inst = bus.inst;
        s_ipc  = bus.inst_pc;
        s_iss  = if_cnt_issue;
        s_dis  = if_cnt_discard;
        @(posedge clk);
        if (rst) begin
            m_pend = 1'b0;
        end else begin
            if (bus.ic_valid) m_pend = 1'b0;
            if (s_oe[0]) begin
                m_pend = 1'b1;
                m_addr = s_addr;
                m_cnt  = lat - 1;
            end else if (m_pend && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        bus.inst_ready = 1'b1;
        lat            = 1;
        cyc();
        check("rst_oe", s_oe, 0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_pend       = 1'b0;
        m_cnt        = 0;
        m_addr       = 32'h0;
        lat          = 1;
        bus.ic_valid = 1'b0;
        bus.ic_rdata = 32'h0;
        @(posedge clk);
        #1;

        // 1: streaming hits, one instruction per cycle from cycle 2
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cyc();
            check($sformatf("t1_oe%0d", c), s_oe, 1);
            check($sformatf("t1_addr%0d", c), s_addr, c);
            if (c >= 2) begin
                check($sformatf("t1_iv%0d", c), s_iv, 1);
                check($sformatf("t1_ipc%0d", c), s_ipc, 4 * (c - 2));
                check($sformatf("t1_inst%0d", c), s_inst, word_of(c - 2));
            end else begin
                check($sformatf("t1_iv%0d", c), s_iv, 0);
            end
        end
        cyc();
        check("t1_issue", s_iss, 8);
        check("t1_discard", s_dis, 0);

        // 2: a 10-cycle miss blocks issue until the response arrives
        do_reset();
        lat = 10;
        cyc();
        check("t2_oe0", s_oe, 1);
        lat = 1;
        for (int c = 1; c < 10; c++) begin
            cyc();
            check($sformatf("t2_oe%0d", c), s_oe, 0);
        end
        cyc();
        check("t2_oe10", s_oe, 1);
        check("t2_addr10", s_addr, 1);
        check("t2_iv10", s_iv, 0);
        for (int c = 11; c < 14; c++) begin
            cyc();
            check($sformatf("t2_iv%0d", c), s_iv, 1);
            check($sformatf("t2_ipc%0d", c), s_ipc, 4 * (c - 11));
        end
        check("t2_issue", s_iss, 4);

        // 3: backpressure fills both entries, head stays stable, then drains in order
        do_reset();
        bus.inst_ready = 1'b0;
        cyc();
        cyc();
        check("t3_oe1", s_oe, 1);
        check("t3_addr1", s_addr, 1);
        for (int c = 2; c < 8; c++) begin
            cyc();
            check($sformatf("t3_oe%0d", c), s_oe, 0);
            check($sformatf("t3_iv%0d", c), s_iv, 1);
            check($sformatf("t3_ipc%0d", c), s_ipc, 0);
            check($sformatf("t3_inst%0d", c), s_inst, word_of(0));
        end
        bus.inst_ready = 1'b1;
        cyc();
        check("t3_oe8", s_oe, 1);
        check("t3_addr8", s_addr, 2);
        check("t3_ipc8", s_ipc, 0);
        for (int c = 9; c < 12; c++) begin
            cyc();
            check($sformatf("t3_ipc%0d", c), s_ipc, 4 * (c - 8));
            check($sformatf("t3_inst%0d", c), s_inst, word_of(c - 8));
        end

        // 4: redirect during a miss drops the old response, then fetches 0x100
        do_reset();
        lat = 5;
        cyc();
        check("t4_oe0", s_oe, 1);
        lat = 1;
        cyc();
        check("t4_oe1", s_oe, 0);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        cyc();
        check("t4_oe2", s_oe, 0);
        redirect = 1'b0;
        for (int c = 3; c < 5; c++) begin
            cyc();
            check($sformatf("t4_oe%0d", c), s_oe, 0);
        end
        cyc();
        check("t4_oe5", s_oe, 1);
        check("t4_addr5", s_addr, 32'h40);
        check("t4_iv5", s_iv, 0);
        cyc();
        check("t4_iv6", s_iv, 0);
        check("t4_discard", s_dis, 1);
        check("t4_addr6", s_addr, 32'h41);
        cyc();
        check("t4_iv7", s_iv, 1);
        check("t4_ipc7", s_ipc, 32'h100);
        check("t4_inst7", s_inst, word_of(32'h40));

        // 5: redirect coinciding with a response and a pop
        do_reset();
        cyc();
        cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        cyc();
        check("t5_oe2", s_oe, 0);
        check("t5_iv2", s_iv, 1);
        check("t5_ipc2", s_ipc, 0);
        redirect = 1'b0;
        cyc();
        check("t5_iv3", s_iv, 0);
        check("t5_oe3", s_oe, 1);
        check("t5_addr3", s_addr, 32'h80);
        check("t5_discard", s_dis, 1);
        cyc();
        check("t5_iv4", s_iv, 0);
        cyc();
        check("t5_iv5", s_iv, 1);
        check("t5_ipc5", s_ipc, 32'h200);
        check("t5_inst5", s_inst, word_of(32'h80));

        // 6: reset during a miss with one entry held
        do_reset();
        bus.inst_ready = 1'b0;
        cyc();
        lat = 20;
        cyc();
        check("t6_oe1", s_oe, 1);
        cyc();
        check("t6_iv2", s_iv, 1);
        check("t6_oe2", s_oe, 0);
        rst = 1'b1;
        cyc();
        check("t6_rst_oe", s_oe, 0);
        rst = 1'b0;
        cyc();
        check("t6_iv4", s_iv, 0);
        check("t6_issue", s_iss, 0);
        check("t6_discard", s_dis, 0);
        check("t6_oe4", s_oe, 1);
        check("t6_addr4", s_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
